// File: rtl/fsmc_master.sv
// FSMC bus initiator: turns single-word read/write commands into multiplexed
// AD/NADV/NWE/NOE bus cycles with programmable phase lengths.
module fsmc_master #(
    parameter int unsigned ADDSET  = 2,
    parameter int unsigned ADDHLD  = 1,
    parameter int unsigned DATAST  = 4,
    parameter int unsigned BUSTURN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [17:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    inout  wire  [17:0] AD,
    output logic        NADV,
    output logic        NWE,
    output logic        NOE
);

    localparam logic [7:0] ADDSET_M1  = 8'(ADDSET - 1);
    localparam logic [7:0] ADDHLD_M1  = 8'(ADDHLD - 1);
    localparam logic [7:0] DATAST_M1  = 8'(DATAST - 1);
    localparam logic [7:0] BUSTURN_M1 = 8'(BUSTURN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AHOLD,
        S_DATA,
        S_TURN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        rsp_q, rsp_d;
    logic        nadv_q, nadv_d;
    logic        nwe_q, nwe_d;
    logic        noe_q, noe_d;
    logic        oe_q, oe_d;
    logic [17:0] ad_q, ad_d;
    logic        last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        last    = (cnt_q == 8'd0);

        if (state_q != S_IDLE && !last) begin
            cnt_d = cnt_q - 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_ADDR;
                    cnt_d   = ADDSET_M1;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end
            end
            S_ADDR: begin
                if (last) begin
                    state_d = S_AHOLD;
                    cnt_d   = ADDHLD_M1;
                end
            end
            S_AHOLD: begin
                if (last) begin
                    state_d = S_DATA;
                    cnt_d   = DATAST_M1;
                end
            end
            S_DATA: begin
                if (last) begin
                    state_d = S_TURN;
                    cnt_d   = BUSTURN_M1;
                    // Read data is sampled on the edge that closes the strobe.
                    if (!write_q) begin
                        rdata_d = AD[15:0];
                    end
                end
            end
            S_TURN: begin
                if (last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are derived from the next state so every pin is registered.
        ready_d = (state_d == S_IDLE);
        rsp_d   = (state_q == S_DATA) && (state_d == S_TURN);
        nadv_d  = (state_d != S_ADDR);
        nwe_d   = !((state_d == S_DATA) && write_d);
        noe_d   = !((state_d == S_DATA) && !write_d);
        oe_d    = (state_d == S_ADDR) || (state_d == S_AHOLD) ||
                  (write_d && ((state_d == S_DATA) || rsp_d));
        ad_d    = ((state_d == S_ADDR) || (state_d == S_AHOLD)) ? addr_d
                                                                  : {addr_d[17:16], wdata_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            ready_q <= 1'b1;
            rsp_q   <= 1'b0;
            nadv_q  <= 1'b1;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            oe_q    <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rsp_q   <= rsp_d;
            nadv_q  <= nadv_d;
            nwe_q   <= nwe_d;
            noe_q   <= noe_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        ad_q    <= ad_d;
    end

    assign AD        = oe_q ? ad_q : 18'bz;
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign NADV      = nadv_q;
    assign NWE       = nwe_q;
    assign NOE       = noe_q;

endmodule

// File: tb/tb_fsmc_master.sv
// Bench for fsmc_master: default and all-ones phase lengths, cycle-accurate
// expected pin timeline plus a response scoreboard.
module tb_fsmc_master;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit done_f [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int GI    = g;
        localparam int AS    = (g == 0) ? 2 : 1;
        localparam int AH    = 1;
        localparam int DS    = (g == 0) ? 4 : 1;
        localparam int BT    = (g == 0) ? 2 : 1;
        localparam int T     = AS + AH + DS + BT;
        localparam int ABORT = (g == 0) ? 5 : 3;

        typedef struct packed {
            logic        nadv;
            logic        nwe;
            logic        noe;
            logic        rdy;
            logic        rsp;
            logic [17:0] ad;
        } exp_t;

        localparam exp_t IDLE_E = '{nadv: 1'b1, nwe: 1'b1, noe: 1'b1, rdy: 1'b1,
                                    rsp: 1'b0, ad: 18'h3FFFF};

        logic        rst;
        logic        cmd_valid;
        logic        cmd_write;
        logic [17:0] cmd_addr;
        logic [15:0] cmd_wdata;
        wire         cmd_ready;
        wire         rsp_valid;
        wire  [15:0] rsp_rdata;
        wire         NADV;
        wire         NWE;
        wire         NOE;
        tri1  [17:0] ad_bus;

        exp_t        tl [MAXC];
        int          cyc = 0;
        int          free_c = 0;
        logic [15:0] last_read = 16'd0;
        logic [15:0] rsp_q [$];
        bit          chk_en = 1'b0;
        logic [15:0] slv_d;

        fsmc_master #(.ADDSET(AS), .ADDHLD(AH), .DATAST(DS), .BUSTURN(BT)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready),
            .cmd_write (cmd_write),
            .cmd_addr  (cmd_addr),
            .cmd_wdata (cmd_wdata),
            .rsp_valid (rsp_valid),
            .rsp_rdata (rsp_rdata),
            .AD        (ad_bus),
            .NADV      (NADV),
            .NWE       (NWE),
            .NOE       (NOE)
        );

        // Slave model: returns the scheduled read word while NOE is low.
        assign slv_d = tl[cyc % MAXC].ad[15:0];
        assign ad_bus[15:0] = NOE ? 16'bz : slv_d;

        always @(posedge clk) cyc <= cyc + 1;

        task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL inst%0d %s cyc=%0d got=%h exp=%h", GI, name, cyc, got, exp);
            end
        endtask

        always @(negedge clk) begin
            if (chk_en && cyc < MAXC) begin
                exp_t e;
                e = tl[cyc];
                chk("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
                chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
                chk("NADV", 32'(NADV), 32'(e.nadv));
                chk("NWE", 32'(NWE), 32'(e.nwe));
                chk("NOE", 32'(NOE), 32'(e.noe));
                chk("AD", 32'(ad_bus), 32'(e.ad));
                chk("strobe_overlap",
                    32'((!NWE && !NOE) || (!NADV && (!NWE || !NOE))), 32'd0);
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL inst%0d rsp_unexpected cyc=%0d got=1 exp=0", GI, cyc);
                    end else begin
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
                    end
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic issue(input bit w, input logic [17:0] ad, input logic [15:0] wd,
                             input logic [15:0] rd, input bit hold, output int a);
            a = (cyc > free_c) ? cyc : free_c;
            if (a + T + 2 >= MAXC) begin
                $display("FAIL inst%0d timeline_overflow cyc=%0d", GI, cyc);
                $fatal(1);
            end
            for (int k = 1; k <= T; k++) begin
                exp_t e;
                e     = IDLE_E;
                e.rdy = 1'b0;
                e.rsp = (k == AS + AH + DS + 1);
                if (k <= AS) begin
                    e.nadv = 1'b0;
                    e.ad   = ad;
                end else if (k <= AS + AH) begin
                    e.ad = ad;
                end else if (k <= AS + AH + DS) begin
                    if (w) begin
                        e.nwe = 1'b0;
                        e.ad  = {ad[17:16], wd};
                    end else begin
                        e.noe = 1'b0;
                        e.ad  = {2'b11, rd};
                    end
                end else if (w && k == AS + AH + DS + 1) begin
                    e.ad = {ad[17:16], wd};
                end
                tl[a + k] = e;
            end
            rsp_q.push_back(w ? last_read : rd);
            if (!w) last_read = rd;
            cmd_valid = 1'b1;
            cmd_write = w;
            cmd_addr  = ad;
            cmd_wdata = wd;
            while (cyc < a) step();
            step();
            free_c = a + T + 1;
            if (!hold) cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = 18'($urandom);
            cmd_wdata = 16'($urandom);
        endtask

        task automatic abort_write(input logic [17:0] ad, input logic [15:0] wd);
            int a;
            issue(1'b1, ad, wd, 16'd0, 1'b0, a);
            while (cyc < a + ABORT) step();
            for (int c = a + ABORT + 1; c <= a + T; c++) tl[c] = IDLE_E;
            void'(rsp_q.pop_back());
            last_read = 16'd0;
            free_c    = a + ABORT + 1;
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rdata_after_rst", 32'(rsp_rdata), 32'd0);
        endtask

        initial begin
            int a;
            logic [17:0] ra;
            logic [15:0] rw;
            bit hold;
            for (int i = 0; i < MAXC; i++) tl[i] = IDLE_E;
            rst       = 1'b1;
            cmd_valid = 1'b0;
            cmd_write = 1'b0;
            cmd_addr  = 18'd0;
            cmd_wdata = 16'd0;
            repeat (3) step();
            rst    = 1'b0;
            chk_en = 1'b1;
            free_c = cyc;
            chk("rdata_reset", 32'(rsp_rdata), 32'd0);

            issue(1'b1, 18'h00012, 16'hA5C3, 16'd0, 1'b0, a);
            repeat (T + 2) step();
            issue(1'b0, 18'h00012, 16'd0, 16'h1234, 1'b0, a);
            repeat (2) step();
            issue(1'b1, 18'h2ABCD, 16'h5A5A, 16'd0, 1'b1, a);
            issue(1'b0, 18'h1C001, 16'd0, 16'hBEEF, 1'b0, a);
            issue(1'b1, 18'h00100, 16'h0F0F, 16'd0, 1'b0, a);
            issue(1'b0, 18'h00200, 16'd0, 16'h7E81, 1'b0, a);
            abort_write(18'h30033, 16'hC0DE);
            issue(1'b1, 18'h00300, 16'h1111, 16'd0, 1'b0, a);

            for (int i = 0; i < 40; i++) begin
                ra = 18'($urandom);
                if (ra == 18'h3FFFF) ra = 18'd0;
                rw = 16'($urandom);
                if (rw == 16'hFFFF) rw = 16'd0;
                hold = ($urandom_range(0, 3) == 0) && (i < 39);
                issue(1'($urandom), ra, rw, 16'($urandom), hold, a);
                if (!hold) repeat ($urandom_range(0, 3)) step();
            end

            while (cyc < free_c + 2) step();
            chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
            done_f[GI] = 1'b1;
        end
    end

    initial begin
        int waited = 0;
        while (!(done_f[0] && done_f[1]) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (!(done_f[0] && done_f[1])) begin
            total++;
            bad++;
            $display("FAIL timeout got=not_done exp=done");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
